// File: rtl/seq_det_if.sv
// seq_det_if: valid/ready serial bit stream between bit source and detector controller
interface seq_det_if;
    logic bit_valid;
    logic bit_in;
    logic bit_ready;
    modport master (output bit_valid, bit_in, input bit_ready);
    modport slave (input bit_valid, bit_in, output bit_ready);
endinterface

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: programmable serial pattern detector running one windowed,
// abortable match-counting session per start command.
module seq_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W = 4,
    parameter int WIN_W = 16,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [WIN_W-1:0]   cfg_window,
    input  logic               start,
    input  logic               abort,
    seq_det_if.slave           bs,
    output logic               busy,
    output logic               done,
    output logic               match_pulse,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
    state_t state, state_n;
    logic [MAX_LEN-1:0] pat, hist, hist_n, mask;
    logic [LEN_W-1:0] len, eff_len, fill, fill_n;
    logic ovl, legal, accept, hit;
    logic [WIN_W-1:0] win, bits, bits_n;
    assign busy = state != S_IDLE;
    assign done = state == S_FIN;
    assign bs.bit_ready = state == S_RUN && !abort;
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) mask[i] = i < int'(len);
        // a start in the same cycle as cfg_we is judged against the new length
        eff_len = cfg_we ? cfg_len : len;
        legal = eff_len != '0 && int'(eff_len) <= MAX_LEN;
        accept = state == S_RUN && bs.bit_valid && !abort;
        hist_n = {hist[MAX_LEN-2:0], bs.bit_in};
        fill_n = fill == len ? len : fill + 1'b1;
        bits_n = bits + 1'b1;
        hit = accept && fill_n == len && ((hist_n ^ pat) & mask) == '0;
        state_n = state == S_IDLE ? (start && legal ? S_RUN : S_IDLE) :
                  state == S_RUN  ? (abort || (accept && win != '0 && bits_n == win) ? S_FIN : S_RUN) :
                  S_IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pat <= '0;
            len <= '0;
            ovl <= 1'b0;
            win <= '0;
            hist <= '0;
            fill <= '0;
            bits <= '0;
            match_pulse <= 1'b0;
            match_count <= '0;
            cfg_err <= 1'b0;
        end else begin
            state <= state_n;
            match_pulse <= hit;
            if (state == S_IDLE) begin
                if (cfg_we) begin
                    pat <= cfg_pattern;
                    len <= cfg_len;
                    ovl <= cfg_overlap;
                    win <= cfg_window;
                end
                if (start) cfg_err <= !legal;
                else if (cfg_we) cfg_err <= 1'b0;
                if (start && legal) begin
                    match_count <= '0;
                    bits <= '0;
                    hist <= '0;
                    fill <= '0;
                end
            end
            if (accept) begin
                hist <= hist_n;
                bits <= bits_n;
                fill <= hit && !ovl ? '0 : fill_n;
                if (hit && match_count != '1) match_count <= match_count + 1'b1;
            end
        end
    end
endmodule
